// File: rtl/alu_pkg.sv
// Shared ALU definitions: select encoding, widths and the result-entry record.
package alu_pkg;

    localparam int ALU_XLEN = 32;
    localparam int ALU_TAGW = 5;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b0001,
        ALU_SLL  = 4'b0010,
        ALU_SLT  = 4'b0011,
        ALU_SLTU = 4'b0100,
        ALU_XOR  = 4'b0101,
        ALU_SRL  = 4'b0110,
        ALU_SRA  = 4'b0111,
        ALU_OR   = 4'b1000,
        ALU_AND  = 4'b1001
    } alu_sel_e;

    localparam logic [3:0] ALU_SEL_MAX = ALU_AND;

    typedef struct packed {
        logic [ALU_XLEN-1:0] result;
        logic [ALU_TAGW-1:0] tag;
        logic                err;
    } alu_entry_t;

    // True when the select is one of the defined alu operations (ADD..AND).
    function automatic logic sel_is_legal(input logic [3:0] sel);
        return sel <= ALU_SEL_MAX;
    endfunction

endpackage

// File: rtl/alu_exec_ctrl_result_fifo.sv
// In-order result FIFO: DEPTH entries, push/pop, occupancy count, sync reset and clear.
module result_fifo
    import alu_pkg::*;
#(
    parameter int  DEPTH   = 2,
    parameter type entry_t = alu_entry_t,
    localparam int PW      = $clog2(DEPTH),
    localparam int CW      = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear_i,
    input  logic          push_i,
    input  entry_t        push_data_i,
    input  logic          pop_i,
    output entry_t        head_o,
    output logic          valid_o,
    output logic [CW-1:0] count_o
);

    entry_t        mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;

    // Pointer and count bookkeeping; clear has the same effect as reset.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || clear_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop_i)  rd_ptr_q <= rd_ptr_q + PW'(1);
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Entry storage written at the tail pointer.
    // NOTE: storage is not reset; the head output is masked to zero whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign valid_o = (count_q != '0);
    assign head_o  = valid_o ? mem_q[rd_ptr_q] : '0;
    assign count_o = count_q;

endmodule

// File: rtl/alu_exec_ctrl.sv
// Execute-stage controller: registers requests onto the alu inputs, captures
// aluOut one cycle later and queues {result, tag, err} for in-order writeback.
module alu_exec_ctrl
    import alu_pkg::*;
#(
    parameter int XLEN  = ALU_XLEN,
    parameter int TAGW  = ALU_TAGW,
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [XLEN-1:0] req_opA,
    input  logic [XLEN-1:0] req_opB,
    input  logic [3:0]      req_sel,
    input  logic [TAGW-1:0] req_tag,
    output logic [XLEN-1:0] alu_opA,
    output logic [XLEN-1:0] alu_opB,
    output logic [3:0]      alu_sel,
    input  logic [XLEN-1:0] alu_out,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] rsp_result,
    output logic [TAGW-1:0] rsp_tag,
    output logic            rsp_err
);

    localparam int CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [XLEN-1:0] result;
        logic [TAGW-1:0] tag;
        logic            err;
    } entry_t;

    logic            issue_valid_q;
    logic            issue_err_q;
    logic [TAGW-1:0] issue_tag_q;
    logic [XLEN-1:0] opa_q;
    logic [XLEN-1:0] opb_q;
    logic [3:0]      sel_q;

    logic [CW-1:0]   fifo_count;
    logic [CW:0]     occupancy;
    logic            fifo_valid;
    logic            accept;
    logic            pop;
    entry_t          push_data;
    entry_t          head;

    // Every op in flight reserves a FIFO slot, so capture can never stall.
    assign occupancy = {1'b0, fifo_count} + (CW+1)'(issue_valid_q);
    assign req_ready = occupancy < (CW+1)'(DEPTH);
    assign accept    = req_valid && req_ready;
    assign pop       = fifo_valid && rsp_ready;

    // Issue register: loads on accept, otherwise holds alu_* steady; flush wins over accept.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            issue_valid_q <= 1'b0;
            issue_err_q   <= 1'b0;
            issue_tag_q   <= '0;
            opa_q         <= '0;
            opb_q         <= '0;
            sel_q         <= ALU_ADD;
        end else begin
            issue_valid_q <= accept;
            if (accept) begin
                opa_q       <= req_opA;
                opb_q       <= req_opB;
                sel_q       <= sel_is_legal(req_sel) ? req_sel : ALU_ADD;
                issue_tag_q <= req_tag;
                issue_err_q <= !sel_is_legal(req_sel);
            end
        end
    end

    // Build the FIFO entry from the alu output; illegal selects store a zero result.
    // NOTE: the whole struct gets a default first so no field can infer a latch.
    always_comb begin
        push_data        = '0;
        push_data.result = issue_err_q ? '0 : alu_out;
        push_data.tag    = issue_tag_q;
        push_data.err    = issue_err_q;
    end

    result_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_result_fifo (
        .clk         (clk),
        .rst         (rst),
        .clear_i     (flush),
        .push_i      (issue_valid_q),
        .push_data_i (push_data),
        .pop_i       (pop),
        .head_o      (head),
        .valid_o     (fifo_valid),
        .count_o     (fifo_count)
    );

    assign alu_opA    = opa_q;
    assign alu_opB    = opb_q;
    assign alu_sel    = sel_q;
    assign rsp_valid  = fifo_valid;
    assign rsp_result = head.result;
    assign rsp_tag    = head.tag;
    assign rsp_err    = head.err;

endmodule
